gcd_requester: RTL and testbench

GCD_REQUESTER -- requirements
Module: gcd_requester

---
 rtl/gcd_pkg.sv | 5 +
 rtl/gcd_requester_if.sv | 18 +
 rtl/gcd_ref_iter.sv | 38 +++
 rtl/gcd_requester.sv | 83 ++++++++
 tb/tb_gcd_requester.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM state type and LFSR taps for the GCD requester.
package gcd_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  localparam logic [15:0] GCD_LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/gcd_requester_if.sv
// gcd_requester_if: operand/result handshake bundle between requester (master) and GCD responder (slave).
interface gcd_requester_if #(parameter int W = 16);
  logic         operands_val;
  logic         operands_rdy;
  logic [W-1:0] operands_bits_A;
  logic [W-1:0] operands_bits_B;
  logic         result_val;
  logic         result_rdy;
  logic [W-1:0] result_bits_data;
  modport master (
    output operands_val, operands_bits_A, operands_bits_B, result_rdy,
    input  operands_rdy, result_val, result_bits_data
  );
  modport slave (
    input  operands_val, operands_bits_A, operands_bits_B, result_rdy,
    output operands_rdy, result_val, result_bits_data
  );
endinterface

// File: rtl/gcd_ref_iter.sv
// gcd_ref_iter: subtractive GCD reference engine, one swap-or-subtract step per cycle; done holds until next load.
module gcd_ref_iter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] result
);
  logic [W-1:0] x, y;
  logic         run;
  assign result = x;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      x    <= '0;
      y    <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      x    <= a;
      y    <= b;
      run  <= 1'b1;
      done <= 1'b0;
    end else if (run) begin
      if (x < y) begin
        x <= y;
        y <= x;
      end else if (y != '0) begin
        x <= x - y;
      end else begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
endmodule

// File: rtl/gcd_requester.sv
// gcd_requester: LFSR-driven GCD request generator with result accumulation.
// Define GCD_REQ_CHECK_EN to build the gcd_ref_iter checker that gates result_rdy and counts wrong results.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [CW-1:0]   num_req,
  input  logic [W-1:0]    seed,
  gcd_requester_if.master bus,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    result_sum,
  output logic [CW-1:0]   err_count
);
  localparam logic [W-1:0] TAPS = W'(GCD_LFSR_TAPS);
  state_t        state;
  logic [W-1:0]  lfsr;
  logic [CW-1:0] cnt, nreq;
  logic          op_fire, res_fire, send, last;
  assign send                = state == SEND;
  assign op_fire             = bus.operands_val && bus.operands_rdy;
  assign res_fire            = bus.result_val && bus.result_rdy;
  assign last                = cnt + 1'b1 == nreq;
  assign bus.operands_val    = send;
  assign bus.operands_bits_A = send ? lfsr : '0;
  assign bus.operands_bits_B = send ? {lfsr[W/2-1:0], lfsr[W-1:W/2]} : '0;
  assign busy                = send || state == WAIT;
  assign done                = state == DONE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      lfsr       <= W'(1);
      cnt        <= '0;
      nreq       <= '0;
      result_sum <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          nreq       <= num_req;
          lfsr       <= seed == '0 ? W'(1) : seed;
          cnt        <= '0;
          result_sum <= '0;
          state      <= num_req == '0 ? DONE : SEND;
        end
        SEND: if (op_fire) begin
          lfsr  <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
          state <= WAIT;
        end
        WAIT: if (res_fire) begin
          result_sum <= result_sum + bus.result_bits_data;
          cnt        <= cnt + 1'b1;
          state      <= last ? DONE : SEND;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef GCD_REQ_CHECK_EN
  logic         ref_done;
  logic [W-1:0] ref_res;
  gcd_ref_iter #(.W(W)) u_ref (
    .clk    (clk),
    .reset  (reset),
    .load   (op_fire),
    .a      (bus.operands_bits_A),
    .b      (bus.operands_bits_B),
    .done   (ref_done),
    .result (ref_res)
  );
  assign bus.result_rdy = state == WAIT && ref_done;
  always_ff @(posedge clk or negedge reset)
    if (!reset) err_count <= '0;
    else if (state == IDLE && start) err_count <= '0;
    else if (res_fire && bus.result_bits_data != ref_res && err_count != '1) err_count <= err_count + 1'b1;
`else
  assign bus.result_rdy = state == WAIT;
  assign err_count      = '0;
`endif
endmodule

// File: tb/tb_gcd_requester.sv
// tb_gcd_requester: directed and random runs checked against a plain-arithmetic model (Euclid GCD, LFSR formula).
module tb_gcd_requester;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_req = '0;
  logic [15:0] seed = '0;
  logic        busy, done;
  logic [15:0] result_sum;
  logic [7:0]  err_count;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] ovr_q[$];

  gcd_requester_if #(.W(16)) bus ();

  gcd_requester #(.W(16), .CW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_req    (num_req),
    .seed       (seed),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .result_sum (result_sum),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] sw(input logic [15:0] l);
    return {l[7:0], l[15:8]};
  endfunction

  function automatic logic [15:0] gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_val"}, bus.operands_val, 0);
    chk({tag, "_rdy"}, bus.result_rdy, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sum"}, result_sum, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_A"}, bus.operands_bits_A, 0);
    chk({tag, "_B"}, bus.operands_bits_B, 0);
  endtask

  task automatic wait_val();
    for (int k = 0; k < 100; k++) begin
      if (bus.operands_val) break;
      @(negedge clk);
    end
    chk("op_val", bus.operands_val, 1);
  endtask

  task automatic do_run(input logic [15:0] sd, input int n, input int stall_i, input int stall_n, input bit poke);
    logic [15:0] l, r, e, sum;
    int err;
    l = sd == 0 ? 16'h0001 : sd;
    sum = 0;
    err = 0;
    start = 1;
    num_req = 8'(n);
    seed = sd;
    @(negedge clk);
    start = 0;
    num_req = 8'($urandom);
    seed = 16'($urandom);
    for (int i = 0; i < n; i++) begin
      wait_val();
      chk("busy_send", busy, 1);
      if (poke && i == 1) begin
        start = 1;
        num_req = 8'd1;
        seed = 16'h1234;
        @(negedge clk);
        start = 0;
      end
      chk("op_A", bus.operands_bits_A, l);
      chk("op_B", bus.operands_bits_B, sw(l));
      if (i == stall_i)
        repeat (stall_n) begin
          @(negedge clk);
          chk("stall_val", bus.operands_val, 1);
          chk("stall_A", bus.operands_bits_A, l);
          chk("stall_B", bus.operands_bits_B, sw(l));
        end
      bus.operands_rdy = 1;
      @(negedge clk);
      bus.operands_rdy = 0;
      chk("wait_val_low", bus.operands_val, 0);
      chk("wait_busy", busy, 1);
      chk("wait_no_done", done, 0);
      e = gcd(l, sw(l));
      r = ovr_q.size() != 0 ? ovr_q.pop_front() : e;
      bus.result_val = 1;
      bus.result_bits_data = r;
      for (int k = 0; k < 3000; k++) begin
        if (bus.result_rdy) break;
        @(negedge clk);
      end
      chk("res_rdy", bus.result_rdy, 1);
      @(negedge clk);
      bus.result_val = 0;
      bus.result_bits_data = 16'($urandom);
      sum = sum + r;
`ifdef GCD_REQ_CHECK_EN
      if (r != e) err++;
`endif
      l = nxt(l);
    end
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_sum", result_sum, sum);
    chk("end_err", err_count, err);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("hold_sum", result_sum, sum);
    chk("hold_err", err_count, err);
  endtask

  initial begin
    int lat, ndone;
    bit busy_seen;
    bus.operands_rdy = 0;
    bus.result_val = 0;
    bus.result_bits_data = 0;
    repeat (3) @(negedge clk);
    chk_idle_zero("rst");
    reset = 1;
    @(negedge clk);
    chk_idle_zero("post_rst");

    start = 1;
    num_req = 0;
    seed = 16'h0005;
    @(negedge clk);
    start = 0;
    lat = 0;
    ndone = 0;
    busy_seen = 0;
    for (int k = 1; k <= 4; k++) begin
      if (done && lat == 0) lat = k;
      if (done) ndone++;
      busy_seen |= busy;
      @(negedge clk);
    end
    chk("zero_done_lat", lat >= 1 && lat <= 2, 1);
    chk("zero_done_width", ndone, 1);
    chk("zero_busy", busy_seen, 0);
    chk("zero_sum", result_sum, 0);

    do_run(16'h0001, 1, -1, 0, 0);
    chk("single_sum", result_sum, 16'h0001);

    do_run(16'h0001, 2, 1, 5, 0);
    chk("stall_sum", result_sum, 16'h00B5);

    ovr_q.push_back(16'h0002);
    do_run(16'h0001, 1, -1, 0, 0);
`ifdef GCD_REQ_CHECK_EN
    chk("bad_err", err_count, 1);
`else
    chk("bad_err", err_count, 0);
`endif
    do_run(16'h0001, 1, -1, 0, 0);
    chk("good_err", err_count, 0);

    do_run(16'h00A5, 3, -1, 0, 1);

    start = 1;
    num_req = 3;
    seed = 16'h0001;
    @(negedge clk);
    start = 0;
    wait_val();
    bus.operands_rdy = 1;
    @(negedge clk);
    bus.operands_rdy = 0;
    chk("mid_busy", busy, 1);
    #2 reset = 0;
    #1 chk_idle_zero("async_rst");
    repeat (2) @(negedge clk);
    chk_idle_zero("hold_rst");
    reset = 1;
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    do_run(16'h0001, 1, -1, 0, 0);

    for (int t = 0; t < 8; t++) begin
      logic [15:0] sd;
      int n;
      sd = $urandom_range(0, 3) == 0 ? 16'h0000 : 16'($urandom);
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++)
        if ($urandom_range(0, 1) == 1) ovr_q.push_back(16'($urandom));
      do_run(sd, n, $urandom_range(0, n - 1), $urandom_range(0, 4), 0);
      ovr_q.delete();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
